// File: rtl/wb_pkg.sv
// Shared definitions for the writeback arbiter: source codes, FSM state type
// and small helpers used by the arbiter and its priority picker.
package wb_pkg;

    localparam int NUM_SRC = 6;
    localparam int RD_W    = 5;

    localparam logic [2:0] SRC_ULA   = 3'd0;
    localparam logic [2:0] SRC_LS    = 3'd1;
    localparam logic [2:0] SRC_HI    = 3'd2;
    localparam logic [2:0] SRC_LO    = 3'd3;
    localparam logic [2:0] SRC_SHIFT = 3'd4;
    localparam logic [2:0] SRC_LT    = 3'd5;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } wb_state_t;

    // Pointer advance after a grant: the source after the winner, 5 wraps to 0.
    function automatic logic [2:0] next_ptr(input logic [2:0] idx);
        next_ptr = (idx >= SRC_LT) ? SRC_ULA : idx + 3'd1;
    endfunction

    function automatic logic [RD_W-1:0] rd_of(input logic [NUM_SRC*RD_W-1:0] rd_bus,
                                             input logic [2:0] idx);
        rd_of = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (idx == 3'(i)) rd_of = rd_bus[RD_W*i +: RD_W];
        end
    endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Rotating-priority picker: first eligible source at or after ptr, scanning
// upward with wrap. With ptr tied to 0 it degenerates to lowest-index-wins.
module wb_rr_pick
    import wb_pkg::*;
(
    input  logic [NUM_SRC-1:0] eligible,
    input  logic [2:0]         ptr,
    output logic [NUM_SRC-1:0] gnt,
    output logic [2:0]         idx,
    output logic               any
);

    logic [3:0] cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = {1'b0, ptr} + 4'(k);
            if (cand >= 4'(NUM_SRC)) cand = cand - 4'(NUM_SRC);
            if (!any && eligible[cand[2:0]]) begin
                any            = 1'b1;
                idx            = cand[2:0];
                gnt[cand[2:0]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: picks one of six sources per two cycles and drives the
// register-file write port. Define WB_ARBITER_RR_EN for round-robin, else fixed priority.
module wb_arbiter
    import wb_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_SRC-1:0]      wb_req,
    input  logic [NUM_SRC*RD_W-1:0] wb_rd,
    input  logic                    muldiv_busy,
    output logic [2:0]              WriteData,
    output logic                    RegWrite,
    output logic [RD_W-1:0]         RegDst,
    output logic [NUM_SRC-1:0]      wb_gnt,
    output logic                    busy
);

    // Handshake: a source raises wb_req with wb_rd stable and holds both until
    // it sees its wb_gnt bit (one WRITE cycle); it drops wb_req the cycle after,
    // and a request still high then is treated as a fresh request.

    wb_state_t          state;
    logic [2:0]         win_q;
    logic [RD_W-1:0]    rd_q;
    logic [NUM_SRC-1:0] gnt_q;

    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] pick_gnt;
    logic [2:0]         pick_idx;
    logic [2:0]         pick_ptr;
    logic               pick_any;

    // HI/LO results are not ready while the multiply/divide unit is running.
    always_comb begin
        eligible = wb_req;
        if (muldiv_busy) begin
            eligible[SRC_HI] = 1'b0;
            eligible[SRC_LO] = 1'b0;
        end
    end

    wb_rr_pick u_pick (
        .eligible (eligible),
        .ptr      (pick_ptr),
        .gnt      (pick_gnt),
        .idx      (pick_idx),
        .any      (pick_any)
    );

`ifdef WB_ARBITER_RR_EN
    logic [2:0] rr_ptr;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr_ptr <= '0;
        end else if (state == ST_IDLE && pick_any) begin
            rr_ptr <= next_ptr(pick_idx);
        end
    end

    assign pick_ptr = rr_ptr;
`else
    assign pick_ptr = 3'd0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            win_q <= '0;
            rd_q  <= '0;
            gnt_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        state <= ST_WRITE;
                        win_q <= pick_idx;
                        rd_q  <= rd_of(wb_rd, pick_idx);
                        gnt_q <= pick_gnt;
                    end
                end
                ST_WRITE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decode only registered state, so late request changes cannot disturb a write.
    assign busy      = (state != ST_IDLE);
    assign WriteData = (state == ST_WRITE) ? win_q : 3'd0;
    assign RegDst    = (state == ST_WRITE) ? rd_q : '0;
    assign RegWrite  = (state == ST_WRITE) && (rd_q != '0);
    assign wb_gnt    = (state == ST_WRITE) ? gnt_q : '0;

endmodule
